// File: rtl/io_pkg.sv
// io_pkg: shared register map defaults and register-select encoding for io_block
package io_pkg;
    localparam logic [7:0] LED_ADDR = 8'h00;
    localparam logic [7:0] SW_ADDR  = 8'h04;
    localparam logic [7:0] CHG_ADDR = 8'h08;
    localparam logic [7:0] ID_ADDR  = 8'h0C;
    localparam logic [7:0] ID_VALUE = 8'hA5;
    typedef enum logic [2:0] {SEL_LED, SEL_SW, SEL_CHG, SEL_ID, SEL_NONE} sel_t;
endpackage

// File: rtl/io_if.sv
// io_if: CPU data-bus signals between the bus master and the io_block peripheral
interface io_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              write_en;
    logic              read_en;
    modport master(output addr, write_data, write_en, read_en, input read_data);
    modport slave(input addr, write_data, write_en, read_en, output read_data);
endinterface

// File: rtl/io_sync.sv
// io_sync: N-bit two-flop synchroniser bringing asynchronous inputs into the clk domain
module io_sync #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);
    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end
    assign o_q = r_s2;
endmodule

// File: rtl/io_block.sv
// io_block: memory-mapped LED, switch, sticky switch-change and ID registers
module io_block #(
    parameter int          ADDR_W   = 8,
    parameter int          DATA_W   = 8,
    parameter int          N_LEDS   = 4,
    parameter int          N_SW     = 4,
    parameter logic [ADDR_W-1:0] LED_ADDR = io_pkg::LED_ADDR,
    parameter logic [ADDR_W-1:0] SW_ADDR  = io_pkg::SW_ADDR,
    parameter logic [ADDR_W-1:0] CHG_ADDR = io_pkg::CHG_ADDR,
    parameter logic [ADDR_W-1:0] ID_ADDR  = io_pkg::ID_ADDR,
    parameter logic [DATA_W-1:0] ID_VALUE = io_pkg::ID_VALUE
) (
    input  logic              clk,
    input  logic              reset_n,
    io_if.slave               bus,
    input  logic [N_SW-1:0]   in_switches,
    output logic [N_LEDS-1:0] out_leds
);
    import io_pkg::*;
    sel_t              w_sel;
    logic [N_SW-1:0]   w_sw;
    logic [N_SW-1:0]   w_chg_set;
    logic [N_SW-1:0]   w_chg_clr;
    logic [DATA_W-1:0] w_rdata;
    logic [N_LEDS-1:0] r_leds;
    logic [N_SW-1:0]   r_prev;
    logic [N_SW-1:0]   r_chg;
    logic [DATA_W-1:0] r_rdata;
    io_sync #(.N(N_SW)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (in_switches),
        .o_q     (w_sw)
    );
    always_comb begin
        w_sel = bus.addr == LED_ADDR ? SEL_LED :
                bus.addr == SW_ADDR  ? SEL_SW  :
                bus.addr == CHG_ADDR ? SEL_CHG :
                bus.addr == ID_ADDR  ? SEL_ID  : SEL_NONE;
        w_rdata = w_sel == SEL_LED ? DATA_W'(r_leds) :
                  w_sel == SEL_SW  ? DATA_W'(w_sw)   :
                  w_sel == SEL_CHG ? DATA_W'(r_chg)  :
                  w_sel == SEL_ID  ? ID_VALUE        : '0;
        w_chg_set = w_sw ^ r_prev;
        w_chg_clr = (bus.write_en && w_sel == SEL_CHG) ? bus.write_data[N_SW-1:0] : '0;
    end
    // a fresh change wins over a same-edge write-1-to-clear so no edge is lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_leds  <= '0;
            r_prev  <= '0;
            r_chg   <= '0;
            r_rdata <= '0;
        end else begin
            r_prev <= w_sw;
            r_chg  <= (r_chg & ~w_chg_clr) | w_chg_set;
            if (bus.write_en && w_sel == SEL_LED)
                r_leds <= bus.write_data[N_LEDS-1:0];
            if (bus.read_en)
                r_rdata <= w_rdata;
        end
    end
    assign out_leds      = r_leds;
    assign bus.read_data = r_rdata;
endmodule

// File: tb/tb_io_block.sv
// tb_io_block: directed self-checking bench for io_block
module tb_io_block;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_switches = 4'b1010;
    logic [3:0] out_leds;
    int         n_chk = 0;
    int         n_fail = 0;

    io_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    io_block dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .in_switches (in_switches),
        .out_leds    (out_leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.write_data = d;
        bus.write_en = 1'b1;
        @(posedge clk);
        #1;
        bus.write_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        @(negedge clk);
        bus.addr = a;
        bus.read_en = 1'b1;
        @(posedge clk);
        #1;
        bus.read_en = 1'b0;
    endtask

    initial begin
        bus.addr = '0;
        bus.write_data = '0;
        bus.write_en = 1'b0;
        bus.read_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_leds", {4'h0, out_leds}, 8'h00);
        chk("rst_rdata", bus.read_data, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_leds", {4'h0, out_leds}, 8'h00);

        wr(8'h00, 8'b0000_1101);
        chk("led_d", {4'h0, out_leds}, 8'h0D);
        wr(8'h00, 8'h03);
        chk("led_3", {4'h0, out_leds}, 8'h03);
        wr(8'h00, 8'hF0);
        chk("led_upper", {4'h0, out_leds}, 8'h00);

        rd(8'h04);
        chk("sw_rd", bus.read_data, 8'h0A);
        @(posedge clk);
        #1;
        chk("sw_hold", bus.read_data, 8'h0A);

        wr(8'h00, 8'h0D);
        rd(8'h00);
        chk("led_rb", bus.read_data, 8'h0D);
        rd(8'h0C);
        chk("id", bus.read_data, 8'hA5);
        rd(8'h10);
        chk("unmapped", bus.read_data, 8'h00);

        wr(8'h04, 8'hFF);
        chk("sw_wr_leds", {4'h0, out_leds}, 8'h0D);
        rd(8'h00);
        chk("sw_wr_ledrb", bus.read_data, 8'h0D);
        rd(8'h04);
        chk("sw_wr_sw", bus.read_data, 8'h0A);

        rd(8'h08);
        chk("chg_init", bus.read_data, 8'h0A);
        wr(8'h08, 8'h0F);
        rd(8'h08);
        chk("chg_w1c", bus.read_data, 8'h00);

        @(negedge clk);
        in_switches = 4'b1011;
        repeat (4) @(posedge clk);
        rd(8'h08);
        chk("chg_toggle", bus.read_data, 8'h01);
        wr(8'h08, 8'h01);
        rd(8'h08);
        chk("chg_clr0", bus.read_data, 8'h00);

        // bit 0 falls; the W1C lands on the very edge the flag sets
        @(negedge clk);
        in_switches = 4'b1010;
        @(posedge clk);
        @(posedge clk);
        wr(8'h08, 8'h01);
        rd(8'h08);
        chk("chg_set_prio", bus.read_data, 8'h01);

        wr(8'h00, 8'h03);
        @(negedge clk);
        bus.addr = 8'h00;
        bus.write_data = 8'h0C;
        bus.write_en = 1'b1;
        bus.read_en = 1'b1;
        @(posedge clk);
        #1;
        bus.write_en = 1'b0;
        bus.read_en = 1'b0;
        chk("rw_old", bus.read_data, 8'h03);
        chk("rw_new", {4'h0, out_leds}, 8'h0C);

        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_leds", {4'h0, out_leds}, 8'h00);
        chk("arst_rdata", bus.read_data, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        rd(8'h08);
        chk("arst_chg", bus.read_data, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
